sha256_msg_feeder: RTL

SHA256_MSG_FEEDER -- requirements
Module: sha256_msg_feeder

---
 rtl/sha256_msg_feeder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_feeder.sv
// Packs a byte stream into SHA-256 padded 512-bit blocks and drives the
// word-write / go / done handshake of a hash core, one block at a time.
module sha256_msg_feeder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic        s_empty,
    output logic        s_ready,
    output logic        core_clear,
    output logic        chipselect,
    output logic        write,
    output logic [3:0]  address,
    output logic [31:0] writedata,
    output logic        go,
    input  logic        core_done,
    output logic        busy,
    output logic        msg_done
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CNT_W  = 64;
    localparam int unsigned ACC_W  = WORD_W - BYTE_W;

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_PAD80, S_PADZ, S_LEN, S_GO, S_WAIT, S_FIN
    } state_t;

    state_t              r_state, w_state_nxt;
    state_t              r_resume, w_resume_nxt;

    logic [IDX_W-1:0]    r_b;
    logic [IDX_W-1:0]    w_b_inc;
    logic [ACC_W-1:0]    r_word;
    logic [CNT_W-1:0]    r_bitcnt;
    logic [CNT_W-1:0]    w_len_sh;
    logic                r_go_pend;
    logic                r_len_done;
    logic                r_first_last;
    logic                r_seen_low;

    logic                r_s_ready;
    logic                r_core_clear;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic                r_go;
    logic                r_busy;
    logic                r_msg_done;

    logic                w_acc;
    logic                w_beat_byte;
    logic                w_app;
    logic [BYTE_W-1:0]   w_app_byte;
    logic                w_count;
    logic                w_word_done;
    logic                w_ready_nxt;

    assign w_acc       = s_valid && r_s_ready;
    assign w_beat_byte = !(s_last && s_empty);
    assign w_b_inc     = r_b + IDX_W'(1);
    assign w_word_done = w_app && (r_b[1:0] == 2'b11);
    // Length bytes go out most significant first at b = 56..63.
    assign w_len_sh    = r_bitcnt >> {~r_b[2:0], 3'b000};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_resume <= S_IDLE;
        end else begin
            r_state  <= w_state_nxt;
            r_resume <= w_resume_nxt;
        end
    end

    // Next state and byte-append selection
    always_comb begin
        w_state_nxt  = r_state;
        w_resume_nxt = r_resume;
        w_app        = 1'b0;
        w_app_byte   = '0;
        w_count      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = S_CLEAR;
                    w_app       = w_beat_byte;
                    w_app_byte  = s_data;
                    w_count     = w_beat_byte;
                end
            end
            S_CLEAR: begin
                w_state_nxt = r_first_last ? S_PAD80 : S_LOAD;
            end
            S_LOAD, S_PAD80, S_PADZ, S_LEN: begin
                if (r_go_pend) begin
                    // Word 15 was written last cycle; launch the block and
                    // remember where to pick up once the core is done.
                    w_resume_nxt = r_state;
                    w_state_nxt  = S_GO;
                end else if (r_state == S_LOAD) begin
                    if (w_acc) begin
                        w_app      = w_beat_byte;
                        w_app_byte = s_data;
                        w_count    = w_beat_byte;
                        if (s_last) begin
                            w_state_nxt = S_PAD80;
                        end
                    end
                end else if (r_state == S_LEN) begin
                    w_app      = 1'b1;
                    w_app_byte = w_len_sh[BYTE_W-1:0];
                end else begin
                    w_app       = 1'b1;
                    w_app_byte  = (r_state == S_PAD80) ? 8'h80 : 8'h00;
                    w_state_nxt = (w_b_inc == IDX_W'(56)) ? S_LEN : S_PADZ;
                end
            end
            S_GO: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_seen_low && core_done) begin
                    w_state_nxt = r_len_done ? S_FIN : r_resume;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_ready_nxt = (w_state_nxt == S_IDLE) ||
                      ((w_state_nxt == S_LOAD) && !w_word_done);
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_b          <= '0;
            r_word       <= '0;
            r_bitcnt     <= '0;
            r_go_pend    <= 1'b0;
            r_len_done   <= 1'b0;
            r_first_last <= 1'b0;
            r_seen_low   <= 1'b0;
            r_s_ready    <= 1'b0;
            r_core_clear <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_go         <= 1'b0;
            r_busy       <= 1'b0;
            r_msg_done   <= 1'b0;
        end else begin
            r_s_ready    <= w_ready_nxt;
            r_core_clear <= (w_state_nxt == S_CLEAR);
            r_go         <= (w_state_nxt == S_GO);
            r_msg_done   <= (w_state_nxt == S_FIN);
            r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
            r_wr         <= w_word_done;
            r_go_pend    <= w_app && (r_b == IDX_W'(63));

            if (w_app) begin
                r_word <= {r_word[ACC_W-BYTE_W-1:0], w_app_byte};
                r_b    <= w_b_inc;
            end
            if (w_word_done) begin
                r_addr  <= r_b[IDX_W-1:2];
                r_wdata <= {r_word, w_app_byte};
            end

            if ((r_state == S_IDLE) && w_acc) begin
                r_bitcnt     <= w_count ? CNT_W'(8) : '0;
                r_first_last <= s_last;
            end else if (w_count) begin
                r_bitcnt <= r_bitcnt + CNT_W'(8);
            end

            if (r_state == S_IDLE) begin
                r_len_done <= 1'b0;
            end else if ((r_state == S_LEN) && w_app && (r_b == IDX_W'(63))) begin
                r_len_done <= 1'b1;
            end

            // Only a low seen after go qualifies the next high as completion.
            if (r_state == S_GO) begin
                r_seen_low <= 1'b0;
            end else if ((r_state == S_WAIT) && !core_done) begin
                r_seen_low <= 1'b1;
            end
        end
    end

    assign s_ready    = r_s_ready;
    assign core_clear = r_core_clear;
    assign chipselect = r_wr;
    assign write      = r_wr;
    assign address    = r_addr;
    assign writedata  = r_wdata;
    assign go         = r_go;
    assign busy       = r_busy;
    assign msg_done   = r_msg_done;

endmodule
